// File: rtl/counter_pkg.sv
// Shared types, constants and the saturating adder for the counter event coalescer.
// Optional feature macro used by the coalescer: COUNTER_COALESCE_NET_EN.
package counter_pkg;

  localparam int unsigned DEF_NUM_SRC = 4;
  localparam int unsigned DEF_PEND_W  = 5;
  localparam int unsigned DEF_VALUE_W = 4;
  localparam int unsigned DEF_STEP_W  = 2;

  localparam int unsigned STEP_MAX = (32'd1 << DEF_STEP_W) - 32'd1;
  localparam int unsigned PEND_MAX = (32'd1 << DEF_PEND_W) - 32'd1;

  typedef enum logic {
    RUN  = 1'b0,
    LOAD = 1'b1
  } coalesce_state_t;

  // Adds at PEND_W+1 bits and clamps to PEND_MAX.
  // Result MSB is the saturation flag, the low DEF_PEND_W bits are the clamped sum.
  function automatic logic [DEF_PEND_W:0] sat_add(
    input logic [DEF_PEND_W-1:0] base,
    input logic [DEF_PEND_W-1:0] add
  );
    logic [DEF_PEND_W:0] sum;
    logic [DEF_PEND_W:0] res;
    sum = {1'b0, base} + {1'b0, add};
    if (sum > (DEF_PEND_W + 1)'(PEND_MAX)) begin
      res = {1'b1, DEF_PEND_W'(PEND_MAX)};
    end else begin
      res = {1'b0, sum[DEF_PEND_W-1:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/counter_evt_popcount.sv
// Combinational population count of one event vector.
module counter_evt_popcount
  import counter_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned CNT_W   = $clog2(NUM_SRC + 1)
) (
  input  logic [NUM_SRC-1:0] evt,
  output logic [CNT_W-1:0]   cnt
);

  // Sum the set bits of the event vector.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      cnt = cnt + CNT_W'(evt[i]);
    end
  end

endmodule

// File: rtl/counter_event_coalescer.sv
// Counter event coalescer: accumulates inc/dec events from NUM_SRC sources into
// saturating pending counts and drains them as registered steps of at most
// 2**STEP_W-1 per cycle; sequences reinit loads into the downstream counter.
// Optional feature: define COUNTER_COALESCE_NET_EN to cancel opposing pending
// events before emission so only the net direction is stepped.
// PEND_W must equal counter_pkg::DEF_PEND_W (the shared saturating adder width).
module counter_event_coalescer
  import counter_pkg::*;
#(
  parameter int unsigned NUM_SRC = DEF_NUM_SRC,
  parameter int unsigned PEND_W  = DEF_PEND_W,
  parameter int unsigned VALUE_W = DEF_VALUE_W,
  parameter int unsigned STEP_W  = DEF_STEP_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] inc_evt,
  input  logic [NUM_SRC-1:0] dec_evt,
  input  logic               reinit_req,
  input  logic [VALUE_W-1:0] reinit_value,
  input  logic               hold,
  output logic               incr_valid,
  output logic [STEP_W-1:0]  incr,
  output logic               decr_valid,
  output logic [STEP_W-1:0]  decr,
  output logic               reinit,
  output logic [VALUE_W-1:0] initial_value,
  output logic [PEND_W-1:0]  pend_inc,
  output logic [PEND_W-1:0]  pend_dec,
  output logic               overflow
);

  localparam int unsigned CNT_W    = $clog2(NUM_SRC + 1);
  localparam int unsigned STEP_LIM = (32'd1 << STEP_W) - 32'd1;

  coalesce_state_t    state_q, state_d;
  logic [PEND_W-1:0]  pend_inc_q, pend_inc_d;
  logic [PEND_W-1:0]  pend_dec_q, pend_dec_d;
  logic               overflow_q, overflow_d;
  logic               incr_valid_q, incr_valid_d;
  logic [STEP_W-1:0]  incr_q, incr_d;
  logic               decr_valid_q, decr_valid_d;
  logic [STEP_W-1:0]  decr_q, decr_d;
  logic               reinit_q, reinit_d;
  logic [VALUE_W-1:0] init_val_q, init_val_d;

  logic [CNT_W-1:0]   ni_s, nd_s;
  logic [PEND_W-1:0]  net_inc_s, net_dec_s;
  logic [PEND_W-1:0]  ei_s, ed_s;
  logic [PEND_W:0]    inc_sum_s, dec_sum_s;

  counter_evt_popcount #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) u_pop_inc (
    .evt (inc_evt),
    .cnt (ni_s)
  );

  counter_evt_popcount #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) u_pop_dec (
    .evt (dec_evt),
    .cnt (nd_s)
  );

  // Next-state: reinit sequencing, optional netting, emission and saturating accumulation.
  always_comb begin
    state_d      = state_q;
    pend_inc_d   = pend_inc_q;
    pend_dec_d   = pend_dec_q;
    overflow_d   = overflow_q;
    incr_valid_d = 1'b0;
    incr_d       = '0;
    decr_valid_d = 1'b0;
    decr_d       = '0;
    reinit_d     = 1'b0;
    init_val_d   = init_val_q;
    net_inc_s    = pend_inc_q;
    net_dec_s    = pend_dec_q;
    ei_s         = '0;
    ed_s         = '0;
    inc_sum_s    = '0;
    dec_sum_s    = '0;

    if (reinit_req) begin
      // Reload from either state: flush pending, drop this cycle's events.
      state_d    = LOAD;
      pend_inc_d = '0;
      pend_dec_d = '0;
      overflow_d = 1'b0;
      init_val_d = reinit_value;
      reinit_d   = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          state_d = RUN;
`ifdef COUNTER_COALESCE_NET_EN
          if (pend_inc_q < pend_dec_q) begin
            net_inc_s = '0;
            net_dec_s = pend_dec_q - pend_inc_q;
          end else begin
            net_inc_s = pend_inc_q - pend_dec_q;
            net_dec_s = '0;
          end
`endif
          if (hold) begin
            ei_s = '0;
            ed_s = '0;
          end else begin
            ei_s = (net_inc_s > PEND_W'(STEP_LIM)) ? PEND_W'(STEP_LIM) : net_inc_s;
            ed_s = (net_dec_s > PEND_W'(STEP_LIM)) ? PEND_W'(STEP_LIM) : net_dec_s;
          end
        end
        LOAD: begin
          // The counter is loading this cycle: no steps, events still accumulate.
          state_d = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase

      inc_sum_s    = sat_add(net_inc_s - ei_s, PEND_W'(ni_s));
      dec_sum_s    = sat_add(net_dec_s - ed_s, PEND_W'(nd_s));
      pend_inc_d   = inc_sum_s[PEND_W-1:0];
      pend_dec_d   = dec_sum_s[PEND_W-1:0];
      overflow_d   = overflow_q | inc_sum_s[PEND_W] | dec_sum_s[PEND_W];
      incr_d       = ei_s[STEP_W-1:0];
      incr_valid_d = (ei_s != '0);
      decr_d       = ed_s[STEP_W-1:0];
      decr_valid_d = (ed_s != '0);
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      pend_inc_q   <= '0;
      pend_dec_q   <= '0;
      overflow_q   <= 1'b0;
      incr_valid_q <= 1'b0;
      incr_q       <= '0;
      decr_valid_q <= 1'b0;
      decr_q       <= '0;
      reinit_q     <= 1'b0;
      init_val_q   <= '0;
    end else begin
      state_q      <= state_d;
      pend_inc_q   <= pend_inc_d;
      pend_dec_q   <= pend_dec_d;
      overflow_q   <= overflow_d;
      incr_valid_q <= incr_valid_d;
      incr_q       <= incr_d;
      decr_valid_q <= decr_valid_d;
      decr_q       <= decr_d;
      reinit_q     <= reinit_d;
      init_val_q   <= init_val_d;
    end
  end

  assign incr_valid    = incr_valid_q;
  assign incr          = incr_q;
  assign decr_valid    = decr_valid_q;
  assign decr          = decr_q;
  assign reinit        = reinit_q;
  assign initial_value = init_val_q;
  assign pend_inc      = pend_inc_q;
  assign pend_dec      = pend_dec_q;
  assign overflow      = overflow_q;

endmodule
